// File: rtl/div_pkg.sv
// ---------------------------------------------------------------------------
// div_pkg
// Shared definitions for the signed iterative divider sequencer.
//   div_state_t : 3-bit controller state encoding (IDLE, ABS, ITER, FIX, DONE)
//   DIV_WL      : default operand/result width
//   DIV_CNT_W   : step-counter width for the default width
// ---------------------------------------------------------------------------
package div_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_ABS  = 3'd1,
      ST_ITER = 3'd2,
      ST_FIX  = 3'd3,
      ST_DONE = 3'd4
   } div_state_t;

   localparam int DIV_WL    = 8;
   localparam int DIV_CNT_W = $clog2(DIV_WL);

endpackage : div_pkg

// File: rtl/abs.sv
// ---------------------------------------------------------------------------
// abs
// Two's-complement negation unit. Negates unconditionally; the caller
// selects between the input and the negated value.
//   a   in  WL : operand
//   neg out WL : -a (truncated to WL bits, so -2^(WL-1) maps to itself)
// ---------------------------------------------------------------------------
module abs #(
   parameter int WL = 8
) (
   input  logic [WL-1:0] a,
   output logic [WL-1:0] neg
);

   assign neg = (~a) + {{(WL-1){1'b0}}, 1'b1};

endmodule : abs

// File: rtl/div_step.sv
// ---------------------------------------------------------------------------
// div_step
// One combinational restoring shift-subtract step.
//   rem      in  WL+1 : partial remainder
//   q        in  WL   : quotient / remaining dividend bits
//   dmag     in  WL   : divisor magnitude
//   rem_nxt  out WL+1 : updated partial remainder
//   q_nxt    out WL   : updated quotient bits
// ---------------------------------------------------------------------------
module div_step #(
   parameter int WL = 8
) (
   input  logic [WL:0]   rem,
   input  logic [WL-1:0] q,
   input  logic [WL-1:0] dmag,
   output logic [WL:0]   rem_nxt,
   output logic [WL-1:0] q_nxt
);

   logic [WL+1:0] shifted_s;
   logic [WL+1:0] trial_s;
   logic [WL-1:0] q_sh_s;

   // Shift {rem, q} left and form the trial subtraction one bit wider so its
   // MSB acts as the borrow/sign bit.
   always_comb begin
      shifted_s = {rem, q[WL-1]};
      q_sh_s    = {q[WL-2:0], 1'b0};
      trial_s   = shifted_s - {2'b00, dmag};
      if (trial_s[WL+1] == 1'b0) begin
         rem_nxt = trial_s[WL:0];
         q_nxt   = q_sh_s | {{(WL-1){1'b0}}, 1'b1};
      end else begin
         rem_nxt = shifted_s[WL:0];
         q_nxt   = q_sh_s;
      end
   end

endmodule : div_step

// File: rtl/signed_div_ctrl.sv
// ---------------------------------------------------------------------------
// signed_div_ctrl
// Sequencer for the signed iterative divider: latches a signed operand pair,
// takes magnitudes, runs WL restoring steps, applies result signs and
// presents a registered quotient/remainder with a one-cycle done pulse.
//   clk, rst            : clock, synchronous active-high reset
//   start               : request, sampled only in IDLE
//   dividend, divisor   : signed operands, sampled with start
//   busy                : high in every state except IDLE
//   done                : one-cycle completion pulse
//   quotient, remainder : truncating quotient, remainder with dividend sign
//   div_by_zero         : divisor was zero
//   ovf                 : -2^(WL-1) / -1 seen; present only when the
//                         DIV_OVF_FLAG_EN macro is defined
// ---------------------------------------------------------------------------
module signed_div_ctrl
   import div_pkg::*;
#(
   parameter int WL = DIV_WL
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [WL-1:0] dividend,
   input  logic [WL-1:0] divisor,
   output logic          busy,
   output logic          done,
   output logic [WL-1:0] quotient,
   output logic [WL-1:0] remainder,
   output logic          div_by_zero
`ifdef DIV_OVF_FLAG_EN
   ,
   output logic          ovf
`endif
);

   localparam int            CW   = $clog2(WL);
   localparam logic [CW-1:0] LAST = CW'(WL - 1);

   div_state_t    state_r;
   logic [WL-1:0] dvd_r;
   logic [WL-1:0] dvs_r;
   logic          q_neg_r;
   logic          r_neg_r;
   logic [WL-1:0] dmag_r;
   logic [WL-1:0] q_r;
   logic [WL:0]   rem_r;
   logic [CW-1:0] cnt_r;

   logic [WL-1:0] neg_a_in_s;
   logic [WL-1:0] neg_b_in_s;
   logic [WL-1:0] neg_a_s;
   logic [WL-1:0] neg_b_s;
   logic [WL-1:0] mag_a_s;
   logic [WL-1:0] mag_b_s;
   logic [WL-1:0] quot_fix_s;
   logic [WL-1:0] rem_fix_s;
   logic [WL:0]   rem_nxt_s;
   logic [WL-1:0] q_nxt_s;

   // The two negation units are time-shared: operand magnitudes in ABS,
   // result sign correction in FIX.
   always_comb begin
      if (state_r == ST_FIX) begin
         neg_a_in_s = q_r;
         neg_b_in_s = rem_r[WL-1:0];
      end else begin
         neg_a_in_s = dvd_r;
         neg_b_in_s = dvs_r;
      end
      mag_a_s    = dvd_r[WL-1] ? neg_a_s : dvd_r;
      mag_b_s    = dvs_r[WL-1] ? neg_b_s : dvs_r;
      quot_fix_s = q_neg_r ? neg_a_s : q_r;
      rem_fix_s  = r_neg_r ? neg_b_s : rem_r[WL-1:0];
   end

   abs #(.WL(WL)) u_neg_a (
      .a   (neg_a_in_s),
      .neg (neg_a_s)
   );

   abs #(.WL(WL)) u_neg_b (
      .a   (neg_b_in_s),
      .neg (neg_b_s)
   );

   div_step #(.WL(WL)) u_step (
      .rem     (rem_r),
      .q       (q_r),
      .dmag    (dmag_r),
      .rem_nxt (rem_nxt_s),
      .q_nxt   (q_nxt_s)
   );

`ifdef DIV_OVF_FLAG_EN
   logic ovf_case_s;

   // The single overflowing operand pair: most negative value divided by -1.
   always_comb begin
      ovf_case_s = (dvd_r == {1'b1, {(WL-1){1'b0}}}) && (dvs_r == {WL{1'b1}});
   end
`endif

   // Controller FSM with registered status and result outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         dvd_r       <= {WL{1'b0}};
         dvs_r       <= {WL{1'b0}};
         q_neg_r     <= 1'b0;
         r_neg_r     <= 1'b0;
         dmag_r      <= {WL{1'b0}};
         q_r         <= {WL{1'b0}};
         rem_r       <= {(WL+1){1'b0}};
         cnt_r       <= {CW{1'b0}};
         busy        <= 1'b0;
         done        <= 1'b0;
         quotient    <= {WL{1'b0}};
         remainder   <= {WL{1'b0}};
         div_by_zero <= 1'b0;
`ifdef DIV_OVF_FLAG_EN
         ovf         <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (start) begin
                  dvd_r   <= dividend;
                  dvs_r   <= divisor;
                  q_neg_r <= dividend[WL-1] ^ divisor[WL-1];
                  r_neg_r <= dividend[WL-1];
                  busy    <= 1'b1;
`ifdef DIV_OVF_FLAG_EN
                  ovf     <= 1'b0;
`endif
                  state_r <= ST_ABS;
               end
            end
            ST_ABS: begin
               if (dvs_r == {WL{1'b0}}) begin
                  quotient    <= {WL{1'b1}};
                  remainder   <= dvd_r;
                  div_by_zero <= 1'b1;
                  done        <= 1'b1;
                  state_r     <= ST_DONE;
               end else begin
                  // Dividend magnitude seeds the shift register; remainder starts empty.
                  q_r     <= mag_a_s;
                  dmag_r  <= mag_b_s;
                  rem_r   <= {(WL+1){1'b0}};
                  cnt_r   <= {CW{1'b0}};
                  state_r <= ST_ITER;
               end
            end
            ST_ITER: begin
               rem_r <= rem_nxt_s;
               q_r   <= q_nxt_s;
               cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
               if (cnt_r == LAST) begin
                  state_r <= ST_FIX;
               end
            end
            ST_FIX: begin
               quotient    <= quot_fix_s;
               remainder   <= rem_fix_s;
               div_by_zero <= 1'b0;
`ifdef DIV_OVF_FLAG_EN
               ovf         <= ovf_case_s;
`endif
               done        <= 1'b1;
               state_r     <= ST_DONE;
            end
            ST_DONE: begin
               busy    <= 1'b0;
               state_r <= ST_IDLE;
            end
            default: begin
               busy    <= 1'b0;
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

endmodule : signed_div_ctrl

// File: tb/tb_signed_div_ctrl.sv
// ---------------------------------------------------------------------------
// tb_signed_div_ctrl
// Directed bench for signed_div_ctrl at WL = 8. Expected values are hand
// computed. The ovf checks are compiled in when DIV_OVF_FLAG_EN is defined.
// ---------------------------------------------------------------------------
module tb_signed_div_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] dividend;
   logic [7:0] divisor;
   logic       busy;
   logic       done;
   logic [7:0] quotient;
   logic [7:0] remainder;
   logic       div_by_zero;
`ifdef DIV_OVF_FLAG_EN
   logic       ovf;
`endif

   int checks = 0;
   int errors = 0;

   signed_div_ctrl #(.WL(8)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
`ifdef DIV_OVF_FLAG_EN
      ,
      .ovf         (ovf)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   // Issue one operation, check busy/done every cycle through the done cycle,
   // then results, then the return to IDLE. Optionally pulse start with other
   // operands at N+4 (must be ignored).
   task automatic run_div(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] eq, input logic [7:0] er, input logic edz,
                          input logic eovf, input int lat, input bit inj);
      @(negedge clk);
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      for (int c = 1; c <= lat; c++) begin
         chk({tag, " busy"}, {7'd0, busy}, 8'd1);
         chk({tag, " done"}, {7'd0, done}, (c == lat) ? 8'd1 : 8'd0);
         if (inj && c == 4) begin
            dividend = 8'd50;
            divisor  = 8'd5;
            start    = 1'b1;
         end
         if (c < lat) begin
            @(posedge clk);
            #1;
            start = 1'b0;
         end
      end
      chk({tag, " quotient"}, quotient, eq);
      chk({tag, " remainder"}, remainder, er);
      chk({tag, " div_by_zero"}, {7'd0, div_by_zero}, {7'd0, edz});
`ifdef DIV_OVF_FLAG_EN
      chk({tag, " ovf"}, {7'd0, ovf}, {7'd0, eovf});
`else
      if (eovf) begin
         // Overflow case completes silently with the wrapped result.
      end
`endif
      @(posedge clk);
      #1;
      chk({tag, " idle busy"}, {7'd0, busy}, 8'd0);
      chk({tag, " idle done"}, {7'd0, done}, 8'd0);
      chk({tag, " held quotient"}, quotient, eq);
   endtask

   initial begin
      rst      = 1'b1;
      start    = 1'b0;
      dividend = 8'd0;
      divisor  = 8'd0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      chk("reset busy", {7'd0, busy}, 8'd0);
      chk("reset done", {7'd0, done}, 8'd0);
      chk("reset quotient", quotient, 8'd0);
      chk("reset remainder", remainder, 8'd0);
      chk("reset div_by_zero", {7'd0, div_by_zero}, 8'd0);
`ifdef DIV_OVF_FLAG_EN
      chk("reset ovf", {7'd0, ovf}, 8'd0);
`endif

      run_div("100/7",   8'd100,  8'd7,   8'd14,  8'd2,   1'b0, 1'b0, 11, 1'b0);
      run_div("-100/7",  8'h9C,   8'd7,   8'hF2,  8'hFE,  1'b0, 1'b0, 11, 1'b0);
      run_div("100/-7",  8'd100,  8'hF9,  8'hF2,  8'd2,   1'b0, 1'b0, 11, 1'b0);
      run_div("-100/-7", 8'h9C,   8'hF9,  8'd14,  8'hFE,  1'b0, 1'b0, 11, 1'b0);
      run_div("7/0",     8'd7,    8'd0,   8'hFF,  8'd7,   1'b1, 1'b0, 2,  1'b0);
      run_div("9/3",     8'd9,    8'd3,   8'd3,   8'd0,   1'b0, 1'b0, 11, 1'b0);
      run_div("-128/-1", 8'h80,   8'hFF,  8'h80,  8'd0,   1'b0, 1'b1, 11, 1'b0);
      run_div("-128/1",  8'h80,   8'd1,   8'h80,  8'd0,   1'b0, 1'b0, 11, 1'b0);
      run_div("127/-128",8'd127,  8'h80,  8'd0,   8'd127, 1'b0, 1'b0, 11, 1'b0);
      run_div("inj",     8'd100,  8'd7,   8'd14,  8'd2,   1'b0, 1'b0, 11, 1'b1);

      // Reset in the middle of a run: 100/7 started at N, rst high in N+5.
      @(negedge clk);
      dividend = 8'd100;
      divisor  = 8'd7;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("pre-rst busy", {7'd0, busy}, 8'd1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("rst busy", {7'd0, busy}, 8'd0);
      chk("rst done", {7'd0, done}, 8'd0);
      chk("rst quotient", quotient, 8'd0);
      chk("rst remainder", remainder, 8'd0);
      chk("rst div_by_zero", {7'd0, div_by_zero}, 8'd0);
      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         #1;
         chk("rst no done", {7'd0, done}, 8'd0);
      end

      run_div("post-rst 100/7", 8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 1'b0, 11, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_signed_div_ctrl

// File: doc/signed_div_ctrl.md
# signed_div_ctrl

Sequencer for the signed iterative divider in the ALU Division path. It captures a signed dividend/divisor pair, forms magnitudes through the two's-complement negation unit, and runs a WL-step restoring shift-subtract loop. It then applies result signs and presents a registered quotient/remainder with a one-cycle `done` pulse. It sits between the ALU op decoder (start/operands) and the ALU result mux.

## Interface
- `WL`, 8: operand/result width in bits (≥ 2).

- `clk` in 1: rising-edge clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: request; sampled only in IDLE.
- `dividend` in WL (signed): sampled with `start`.
- `divisor` in WL (signed): sampled with `start`.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse; `quotient`/`remainder`/flags valid and held until next accepted `start`.
- `quotient` out WL (signed): truncating (toward zero) quotient.
- `remainder` out WL (signed): remainder, sign of dividend.
- `div_by_zero` out 1: set with `done` when divisor == 0.
- `ovf` out 1: only with `DIV_OVF_FLAG_EN`; see Configuration.

## Operation
- States: IDLE, ABS, ITER, FIX, DONE.
- IDLE + `start` → ABS. Latch operands. Latch `q_neg = dividend[WL-1] ^ divisor[WL-1]` and `r_neg = dividend[WL-1]`.
- ABS:
  - Magnitude = operand if sign bit 0, else negated operand. Magnitude is held as a WL-bit unsigned value, so −2^(WL−1) maps to 2^(WL−1).
  - Divisor == 0 → DONE with `quotient` = all ones, `remainder` = raw dividend, `div_by_zero` = 1.
  - Otherwise clear partial remainder (WL+1 bits) and step counter, then → ITER.
- ITER, one step per cycle:
  - Shift {rem, q} left by 1.
  - Trial = rem − |divisor|.
  - If trial ≥ 0: rem = trial, q LSB = 1.
  - After exactly WL steps (counter wraps at WL−1) → FIX.
- FIX:
  - quotient = `q_neg` ? −q : q, truncated to WL bits.
  - remainder = `r_neg` ? −rem : rem, truncated to WL bits.
  - Register results → DONE.
- DONE: `done` = 1 for this cycle → IDLE.
- `start` outside IDLE is ignored; it is not queued.
- Overflow case −2^(WL−1) / −1: quotient wraps to −2^(WL−1), remainder 0. No trap.

## Timing
- Cycle N: `start` high in IDLE.
- Normal path:
  - ABS at N+1.
  - ITER from N+2 to N+WL+1.
  - FIX at N+WL+2.
  - `done` at N+WL+3 (N+11 for WL=8).
- Divide-by-zero path: `done` at N+2.
- `busy` is high from N+1 through the `done` cycle inclusive. The earliest next accepted `start` is the cycle after `done`.
- Result outputs are registered and change only in FIX or ABS-with-zero-divisor. They hold their value otherwise.
- Reset values: state IDLE; `busy`, `done`, `div_by_zero`, `ovf` = 0; `quotient`, `remainder` = 0.
- Reset mid-operation: abort to IDLE next cycle. No `done` pulse. Outputs cleared.

## Configuration
- `DIV_OVF_FLAG_EN` defined:
  - `ovf` port exists.
  - Set with `done` when dividend = −2^(WL−1) and divisor = −1.
  - Otherwise 0. Cleared at the next accepted `start`.
- `DIV_OVF_FLAG_EN` undefined: no `ovf` port. The overflow case produces the wrapped result silently.

## Structure
- Shared package `div_pkg` holds:
  - State encoding constants (3-bit): IDLE, ABS, ITER, FIX, DONE.
  - Default `WL`.
  - Step-counter width `$clog2(WL)`.
- The existing `abs` negation unit, which negates unconditionally, is instantiated twice:
  - Operand magnitudes, time-shared between ABS and FIX.
  - The controller muxes in/negated by the latched sign bit.
- One new sub-module `div_step` holds the combinational restoring step: (rem, q, |divisor|) → (rem', q').

## Test plan (WL=8)
- 100 / 7, `start` at N → `done` at N+11, q=14, r=2, `busy` high N+1..N+11.
- −100 / 7 → q=−14, r=−2. Also 100 / −7 → q=−14, r=2. Also −100 / −7 → q=14, r=−2.
- 7 / 0 → `done` at N+2, `div_by_zero`=1, q=8'hFF, r=7. The following 9 / 3 gives q=3, r=0, `div_by_zero`=0.
- −128 / −1 → q=−128, r=0, `ovf`=1 with macro defined. Also −128 / 1 → q=−128, `ovf`=0.
- `start` pulsed at N+4 with new operands during a busy run → ignored; first result unchanged at N+11.
- `rst` asserted at N+5 → IDLE at N+6, all outputs 0, no `done`. A fresh 100 / 7 afterwards completes normally.
